// File: rtl/sema_slot_arbiter.sv
// Round-robin arbiter granting one-bit writes into a shared semaphore slot; holds
// off every producer until the consumer drains the slot and flags a stuck consumer.
module sema_slot_arbiter #(
   parameter int N_REQ   = 4,
   parameter int TMO_CYC = 16
) (
   input  logic                     clk_s,
   input  logic                     rstn_s,
   input  logic [N_REQ-1:0]         req_valid_s,
   input  logic [N_REQ-1:0]         req_data_s,
   output logic [N_REQ-1:0]         req_ready_s,
   output logic                     arb_write_s,
   output logic                     arb_data_s,
   input  logic                     slot_empty_s,
   output logic [$clog2(N_REQ)-1:0] grant_id_s,
   output logic                     busy_s,
   output logic                     err_tmo_s
);

   localparam int IDW = $clog2(N_REQ);
   // A zero threshold disables the timeout, but the counter still needs one bit.
   localparam int TW  = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      FILLED = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   state_t           state_q;
   logic [IDW-1:0]   last_q;
   logic [IDW-1:0]   grant_q;
   logic             data_q;
   logic             write_q;
   logic [N_REQ-1:0] ready_q;
   logic [TW-1:0]    cnt_q;
   logic             err_q;

   logic [IDW:0]     win_d;
   logic             win_vld_d;
   logic [IDW-1:0]   win_idx_d;
   logic [TW-1:0]    cnt_d;

   // Scan from the farthest candidate to the nearest so the nearest valid after
   // last wins; last itself is considered only when nobody else is pending.
   function automatic logic [IDW:0] rr_pick(input logic [N_REQ-1:0] vld,
                                            input logic [IDW-1:0]   last);
      logic [IDW:0]   res;
      logic [IDW-1:0] idx_t;
      int             idx;
      res = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         idx   = (int'(last) + i) % N_REQ;
         idx_t = IDW'(idx);
         if (vld[idx_t]) res = {1'b1, idx_t};
      end
      return res;
   endfunction

   function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] c);
      if (c == TW'(TMO_CYC)) return c;
      return c + TW'(1);
   endfunction

   assign win_d     = rr_pick(req_valid_s, last_q);
   assign win_vld_d = win_d[IDW];
   assign win_idx_d = win_d[IDW-1:0];
   assign cnt_d     = sat_inc(cnt_q);

   always_ff @(posedge clk_s or negedge rstn_s) begin
      if (!rstn_s) begin
         state_q <= IDLE;
         last_q  <= IDW'(N_REQ - 1);
         grant_q <= '0;
         data_q  <= 1'b0;
         write_q <= 1'b0;
         ready_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // Only an empty slot may be written; this is the no-overwrite guard.
               if (slot_empty_s && win_vld_d) begin
                  state_q <= WRITE;
                  grant_q <= win_idx_d;
                  last_q  <= win_idx_d;
                  data_q  <= req_data_s[win_idx_d];
                  write_q <= 1'b1;
                  ready_q <= N_REQ'(1) << win_idx_d;
               end
            end
            WRITE: begin
               write_q <= 1'b0;
               ready_q <= '0;
               state_q <= FILLED;
            end
            FILLED: begin
               if (!slot_empty_s) begin
                  state_q <= DRAIN;
                  cnt_q   <= '0;
               end
            end
            DRAIN: begin
               if (slot_empty_s) begin
                  state_q <= IDLE;
               end else if (TMO_CYC != 0) begin
                  cnt_q <= cnt_d;
                  if (cnt_d == TW'(TMO_CYC)) err_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready_s = ready_q;
   assign arb_write_s = write_q;
   assign arb_data_s  = data_q;
   assign grant_id_s  = grant_q;
   assign busy_s      = (state_q != IDLE);
   assign err_tmo_s   = err_q;

endmodule
